// File: rtl/regarb_pkg.sv
// Shared types and requester IDs for the register-file write-port arbiter.
package regarb_pkg;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned GID_W   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [GID_W-1:0] REQ_ALU     = 2'd0;
   localparam logic [GID_W-1:0] REQ_MEM     = 2'd1;
   localparam logic [GID_W-1:0] REQ_DBG     = 2'd2;
   localparam logic [GID_W-1:0] GRANT_SWEEP = 2'd3;

   // (a + b) mod 3 for operands already in 0..2
   function automatic logic [GID_W-1:0] add_mod3(input logic [GID_W-1:0] a,
                                                  input logic [GID_W-1:0] b);
      logic [GID_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 3'd3) s = s - 3'd3;
      return s[GID_W-1:0];
   endfunction

endpackage

// File: rtl/regarb_pick.sv
// Three-way request picker: searches valids starting at i_start and wraps.
// A start of 0 gives fixed priority ALU > MEM > DBG.
module regarb_pick
   import regarb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [GID_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [GID_W-1:0]   o_idx,
   output logic               o_any
);

   logic [NUM_REQ-1:0] w_rot;
   logic [GID_W-1:0]   w_start;
   logic [GID_W-1:0]   w_ofs;

   // Rotate so bit 0 is the requester the search begins at
   always_comb begin
      w_start = i_start;
      w_rot   = i_valid;
      case (i_start)
         2'd1:    w_rot = {i_valid[0], i_valid[2:1]};
         2'd2:    w_rot = {i_valid[1:0], i_valid[2]};
         2'd3:    w_start = 2'd0;
         default: w_rot = i_valid;
      endcase
   end

   always_comb begin
      w_ofs = 2'd2;
      if (w_rot[0])      w_ofs = 2'd0;
      else if (w_rot[1]) w_ofs = 2'd1;
   end

   assign o_any   = |i_valid;
   assign o_idx   = add_mod3(w_start, w_ofs);
   assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter (ALU / MEM / DBG) with a zero-fill sweep.
// Define REGARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module regfile_write_arbiter
   import regarb_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
)(
   input  logic                      clock_in,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_start,
   output logic                      clear_busy,
   output logic                      regWrite,
   output logic [ADDR_W-1:0]         writeReg,
   output logic [DATA_W-1:0]         writeData,
   output logic [GID_W-1:0]          grant_id
);

   state_t              r_state,      w_nxt_state;
   logic [ADDR_W-1:0]   r_clr_idx,    w_nxt_clr_idx;
   logic                r_write_en,   w_nxt_write_en;
   logic [ADDR_W-1:0]   r_write_reg,  w_nxt_write_reg;
   logic [DATA_W-1:0]   r_write_data, w_nxt_write_data;
   logic [GID_W-1:0]    r_grant_id,   w_nxt_grant_id;
   logic [NUM_REQ-1:0]  w_ready;

   logic [NUM_REQ-1:0]  w_pick_grant;
   logic [GID_W-1:0]    w_pick_idx;
   logic                w_pick_any;
   logic [GID_W-1:0]    w_pick_start;

   // Unpacked views of the packed request buses; slot 3 is never selected
   logic [ADDR_W-1:0]   w_addr_arr [4];
   logic [DATA_W-1:0]   w_data_arr [4];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end
   assign w_addr_arr[3] = '0;
   assign w_data_arr[3] = '0;

`ifdef REGARB_ROUND_ROBIN_EN
   logic [GID_W-1:0] r_rr_ptr, w_nxt_rr_ptr;
   assign w_pick_start = r_rr_ptr;
`else
   assign w_pick_start = REQ_ALU;
`endif

   regarb_pick u_pick (
      .i_valid (req_valid),
      .i_start (w_pick_start),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // Next-state and next-output logic
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_clr_idx    = r_clr_idx;
      w_nxt_write_en   = 1'b0;
      w_nxt_write_reg  = r_write_reg;
      w_nxt_write_data = r_write_data;
      w_nxt_grant_id   = r_grant_id;
      w_ready          = '0;
`ifdef REGARB_ROUND_ROBIN_EN
      w_nxt_rr_ptr     = r_rr_ptr;
`endif
      case (r_state)
         ST_IDLE: begin
            if (clear_start) begin
               w_nxt_state   = ST_CLEAR;
               w_nxt_clr_idx = '0;
            end else begin
               w_ready = w_pick_grant;
               if (w_pick_any) begin
                  // Writes to $0 are acknowledged but never reach the file
                  w_nxt_write_en   = (w_addr_arr[w_pick_idx] != '0);
                  w_nxt_write_reg  = w_addr_arr[w_pick_idx];
                  w_nxt_write_data = w_data_arr[w_pick_idx];
                  w_nxt_grant_id   = w_pick_idx;
`ifdef REGARB_ROUND_ROBIN_EN
                  w_nxt_rr_ptr     = add_mod3(w_pick_idx, 2'd1);
`endif
               end
            end
         end
         ST_CLEAR: begin
            w_nxt_write_en   = 1'b1;
            w_nxt_write_reg  = r_clr_idx;
            w_nxt_write_data = '0;
            w_nxt_grant_id   = GRANT_SWEEP;
            w_nxt_clr_idx    = r_clr_idx + ADDR_W'(1);
            if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
               w_nxt_state = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_clr_idx    <= '0;
         r_write_en   <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
         r_grant_id   <= REQ_ALU;
      end else begin
         r_state      <= w_nxt_state;
         r_clr_idx    <= w_nxt_clr_idx;
         r_write_en   <= w_nxt_write_en;
         r_write_reg  <= w_nxt_write_reg;
         r_write_data <= w_nxt_write_data;
         r_grant_id   <= w_nxt_grant_id;
      end
   end

`ifdef REGARB_ROUND_ROBIN_EN
   always_ff @(posedge clock_in) begin
      if (reset) r_rr_ptr <= REQ_ALU;
      else       r_rr_ptr <= w_nxt_rr_ptr;
   end
`endif

   assign req_ready  = w_ready;
   assign clear_busy = (r_state == ST_CLEAR);
   assign regWrite   = r_write_en;
   assign writeReg   = r_write_reg;
   assign writeData  = r_write_data;
   assign grant_id   = r_grant_id;

endmodule
